// File: rtl/enemy_ai.sv
// Enemy behaviour controller: walk/fire/guard/stun FSM with fire cooldown,
// hit latch and 16-bit Galois LFSR, stepped once per frame tick.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tick              one-clk frame pulse
//   enable            game running; low forces IDLE
//   xPlayer           player x (signed 11b)
//   goodE, xGood      player bullet present / its x (signed 11b)
//   hitE              one-clk pulse: player bullet hit the enemy
//   xEnemy, yEnemy    registered enemy position
//   attack, defend    registered; high while in FIRE / GUARD
//   state             debug encoding IDLE=0 WALK=1 FIRE=2 GUARD=3 STUN=4
module enemy_ai #(
    parameter logic signed [10:0] X_INIT          = 11'sd400,
    parameter logic signed [9:0]  Y_INIT          = 10'sd0,
    parameter logic signed [10:0] X_MIN           = 11'sd0,
    parameter logic signed [10:0] X_MAX           = 11'sd600,
    parameter logic signed [10:0] STEP_X          = 11'sd2,
    parameter logic signed [11:0] DIST_NEAR       = 12'sd150,
    parameter logic signed [11:0] DIST_FAR        = 12'sd300,
    parameter logic [7:0]         ATTACK_COOLDOWN = 8'd60,
    parameter logic [5:0]         DEFEND_FRAMES   = 6'd30,
    parameter logic [5:0]         STUN_FRAMES     = 6'd20,
    parameter logic signed [11:0] THREAT_RANGE    = 12'sd120,
    parameter logic [15:0]        LFSR_SEED       = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               enable,
    input  logic signed [10:0] xPlayer,
    input  logic               goodE,
    input  logic signed [10:0] xGood,
    input  logic               hitE,
    output logic signed [10:0] xEnemy,
    output logic signed [9:0]  yEnemy,
    output logic               attack,
    output logic               defend,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WALK  = 3'd1;
    localparam logic [2:0] S_FIRE  = 3'd2;
    localparam logic [2:0] S_GUARD = 3'd3;
    localparam logic [2:0] S_STUN  = 3'd4;

    localparam logic signed [11:0] XMIN_E = {X_MIN[10], X_MIN};
    localparam logic signed [11:0] XMAX_E = {X_MAX[10], X_MAX};
    localparam logic signed [11:0] STEP_E = {STEP_X[10], STEP_X};

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    logic [2:0]         state_q, state_d;
    logic signed [10:0] x_q, x_d;
    logic signed [9:0]  y_q;
    logic [7:0]         cd_q, cd_d;
    logic [5:0]         timer_q, timer_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               hit_q, hit_d;
    logic               attack_q, attack_d;
    logic               defend_q, defend_d;

    logic signed [11:0] x_ext;
    logic signed [11:0] dx;
    logic signed [11:0] bdist;
    logic signed [11:0] x_step;
    logic signed [10:0] x_clamp;
    logic [15:0]        lfsr_nx;
    logic               threat;
    logic               hit_now;
    logic               adv;

    // 12-bit signed working width keeps all differences exact.
    assign x_ext = {x_q[10], x_q};
    assign dx    = x_ext - {xPlayer[10], xPlayer};
    assign bdist = x_ext - {xGood[10], xGood};

    assign threat = goodE && !bdist[11] &&
                    (bdist <= THREAT_RANGE) && lfsr_q[0];

    // A hit in the same cycle as the tick counts as already latched.
    assign hit_now = hit_q | hitE;

    assign adv = enable & tick;

    assign lfsr_nx = {1'b0, lfsr_q[15:1]} ^
                     (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        x_step = x_ext;
        if (dx > DIST_FAR) begin
            x_step = x_ext - STEP_E;
        end else if (dx < DIST_NEAR) begin
            x_step = x_ext + STEP_E;
        end
    end

    always_comb begin
        x_clamp = x_step[10:0];
        if (x_step < XMIN_E) begin
            x_clamp = X_MIN;
        end else if (x_step > XMAX_E) begin
            x_clamp = X_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cd_d    = cd_q;
        timer_d = timer_q;
        hit_d   = hit_q | hitE;
        lfsr_d  = adv ? lfsr_nx : lfsr_q;

        if (!enable) begin
            state_d = S_IDLE;
            cd_d    = ATTACK_COOLDOWN;
            timer_d = 6'd0;
            hit_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WALK;
                end

                S_WALK: begin
                    if (tick) begin
                        if (hit_now) begin
                            state_d = S_STUN;
                            timer_d = STUN_FRAMES;
                            hit_d   = 1'b0;
                        end else if (threat) begin
                            state_d = S_GUARD;
                            timer_d = DEFEND_FRAMES;
                            hit_d   = 1'b0;
                        end else if (cd_q == 8'd0) begin
                            state_d = S_FIRE;
                        end else begin
                            cd_d = cd_q - 8'd1;
                            x_d  = x_clamp;
                        end
                    end
                end

                // Single-cycle shot; jitter the next cooldown.
                S_FIRE: begin
                    state_d = S_WALK;
                    cd_d    = ATTACK_COOLDOWN + {4'd0, lfsr_q[3:0]};
                end

                // Guarding blocks hits entirely.
                S_GUARD: begin
                    hit_d = 1'b0;
                    if (tick) begin
                        if (timer_q <= 6'd1) begin
                            state_d = S_WALK;
                            timer_d = 6'd0;
                        end else begin
                            timer_d = timer_q - 6'd1;
                        end
                    end
                end

                S_STUN: begin
                    if (tick) begin
                        if (hit_now) begin
                            timer_d = STUN_FRAMES;
                            hit_d   = 1'b0;
                        end else if (timer_q <= 6'd1) begin
                            state_d = S_WALK;
                            timer_d = 6'd0;
                        end else begin
                            timer_d = timer_q - 6'd1;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cd_d    = ATTACK_COOLDOWN;
                    timer_d = 6'd0;
                    hit_d   = 1'b0;
                end
            endcase
        end
    end

    assign attack_d = (state_d == S_FIRE);
    assign defend_d = (state_d == S_GUARD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= X_INIT;
            y_q      <= Y_INIT;
            cd_q     <= ATTACK_COOLDOWN;
            timer_q  <= 6'd0;
            lfsr_q   <= LFSR_SEED;
            hit_q    <= 1'b0;
            attack_q <= 1'b0;
            defend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= Y_INIT;
            cd_q     <= cd_d;
            timer_q  <= timer_d;
            lfsr_q   <= lfsr_d;
            hit_q    <= hit_d;
            attack_q <= attack_d;
            defend_q <= defend_d;
        end
    end

    assign xEnemy = x_q;
    assign yEnemy = y_q;
    assign attack = attack_q;
    assign defend = defend_q;
    assign state  = state_q;

endmodule

// File: doc/enemy_ai.md
# enemy_ai

Enemy behaviour controller for the duel game. Runs once per video frame tick and drives the enemy's position plus the `attack`/`defend` commands consumed directly by the enemy-bullet stage. That stage spawns a leftward bullet at `xEnemy - PLAYER_X - BULLET_X` when `attack && !defend`. Decisions come from a 5-state FSM, a fire-cooldown counter and a 16-bit LFSR, so the enemy reacts to the player's position and the player's bullet.

## Interface

**Parameters**

- X_INIT, 400 — reset/initial enemy x (signed 11b).
- Y_INIT, 0 — enemy y; constant, ground level (signed 10b).
- X_MIN / X_MAX, 0 / 600 — clamp range for xEnemy, inclusive.
- STEP_X, 2 — x step per tick while walking.
- DIST_NEAR / DIST_FAR, 150 / 300 — preferred band for dx = xEnemy − xPlayer.
- ATTACK_COOLDOWN, 60 — base ticks between shots.
- DEFEND_FRAMES, 30 — guard duration in ticks.
- STUN_FRAMES, 20 — hit-stun duration in ticks.
- THREAT_RANGE, 120 — player-bullet distance that triggers a guard decision.
- LFSR_SEED, 16'hACE1 — nonzero LFSR reset value.

**Ports**

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  one-clk pulse per frame.
- enable  in  1  game running.
- xPlayer  in  11 signed  player x.
- goodE  in  1  player bullet exists.
- xGood  in  11 signed  player bullet x.
- hitE  in  1  one-clk pulse: player bullet hit the enemy.
- xEnemy  out  11 signed  registered enemy x.
- yEnemy  out  10 signed  registered enemy y, always Y_INIT.
- attack  out  1  registered; high exactly while state = FIRE.
- defend  out  1  registered; high exactly while state = GUARD.
- state  out  3  debug encoding: IDLE=0, WALK=1, FIRE=2, GUARD=3, STUN=4.

## Operation

**Reset values**

- state = IDLE, xEnemy = X_INIT, yEnemy = Y_INIT, attack = 0, defend = 0.
- cooldown = ATTACK_COOLDOWN, timer = 0, lfsr = LFSR_SEED.

**LFSR**

- Galois, shift right, taps 16'hB400.
- Advances on every tick while enable = 1.
- Every decision made on a tick uses the value from before that tick's advance.

**IDLE**

- enable = 0 from any state forces IDLE on the next clk edge.
- Entering IDLE reloads cooldown = ATTACK_COOLDOWN and clears timer; xEnemy is held.
- enable = 1 moves IDLE to WALK on the next clk edge.

**WALK** — evaluated on tick only, first match wins:

1. hitE (latched; see below) → STUN, timer = STUN_FRAMES.
2. Threat → GUARD, timer = DEFEND_FRAMES. Threat means goodE && 0 ≤ xEnemy − xGood ≤ THREAT_RANGE && lfsr[0] = 1.
3. cooldown = 0 → FIRE.
4. Otherwise: decrement cooldown and move.
   - dx > DIST_FAR: x −= STEP_X.
   - dx < DIST_NEAR: x += STEP_X.
   - Otherwise hold x.
   - Clamp the result to [X_MIN, X_MAX].

**FIRE**

- Lasts exactly one clk cycle, independent of tick.
- Next state is WALK with cooldown = ATTACK_COOLDOWN + lfsr[3:0].

**GUARD**

- x and cooldown are frozen.
- timer decrements on tick; at timer = 0 on a tick, go to WALK.
- hitE is ignored (blocked).

**STUN**

- x and cooldown are frozen; attack = defend = 0.
- timer decrements on tick; at timer = 0 on a tick, go to WALK.
- A new hitE reloads timer = STUN_FRAMES.

**Hit capture**

- hitE is captured into a sticky flag in any cycle. It is consumed on the next tick in WALK or STUN and cleared on entry to GUARD or IDLE.
- A hit arriving during FIRE still lets the attack pulse complete; STUN follows on the next WALK tick.

**Arithmetic**

- dx and the bullet distance are computed in 12-bit signed; no wrap.
- The clamp is applied before the register update.

## Timing

- All outputs are registered; attack and defend depend only on state.
- attack and defend are never high together.
- attack is a 1-clk pulse, asserted the clk cycle after the tick that selected FIRE.
- Position updates land one clk after the tick.
- Reset asserted mid-operation returns all registers to their reset values asynchronously. An in-flight FIRE pulse is dropped.
- tick and hitE in the same cycle while in WALK: the hit has priority on that tick.

## Test plan

- **Approach and fire:** reset, enable = 1, xPlayer = −200, goodE = 0.
  - Ticks 1–60: x drops by 2 per tick (x = 380 after tick 10), clamped at X_MIN.
  - Tick 61: no move; attack = 1 for exactly one clk; cooldown reloads to 60 + lfsr[3:0] per the model.
- **Retreat and clamp:** xPlayer = 500, x = 598. One tick gives x = 600; further ticks hold 600.
- **Guard:** first tick after enable with goodE = 1, xGood = 300, x = 400 (seed bit0 = 1).
  - defend = 1 for 30 ticks, then WALK.
  - hitE during the guard produces no STUN.
- **Stun:** hitE pulse in WALK; next tick → STUN for 20 ticks with attack = 0.
  - A second hitE at stun tick 10 extends the stun to 20 more ticks.
- **Disable:** enable = 0 mid-GUARD → IDLE next clk, defend = 0, x held.
  - Re-enable → WALK; first shot comes after 60 ticks.
- **Reset:** rst_n = 0 during FIRE → attack = 0 immediately, x = 400, state = IDLE.
